// File: rtl/hilo_mult_ctrl.sv
// Sequencer for the shared combinational signed multiplier: latches operands, waits a fixed
// settle window, fixes up MULTU results and owns the architectural HI/LO registers.
module hilo_mult_ctrl #(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_unsigned,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        mult_ena,
   output logic        mult_reset,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [63:0] mult_z,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] mult_a_q, mult_b_q;
   logic        unsigned_q;
   logic [31:0] hi_q, lo_q;
   logic        accept;
   logic        capture;
   logic [63:0] corr_a, corr_b, product;

   assign mult_reset = ~reset;
   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign hi         = hi_q;
   assign lo         = lo_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      capture  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      mult_ena = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) accept = 1'b1;
         end
         StRun: begin
            busy     = 1'b1;
            mult_ena = 1'b1;
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
            // Back-to-back issue: the DONE cycle accepts a new request like IDLE.
            if (start) accept = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (accept) begin
         state_d = StRun;
         cnt_d   = 4'(MULT_CYCLES);
      end
   end

   // Signed product reinterpreted as unsigned by adding back the sign-bit weights (mod 2^64).
   always_comb begin
      corr_a  = mult_a_q[31] ? {mult_b_q, 32'b0} : 64'b0;
      corr_b  = mult_b_q[31] ? {mult_a_q, 32'b0} : 64'b0;
      product = unsigned_q ? (mult_z + corr_a + corr_b) : mult_z;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         mult_a_q   <= 32'b0;
         mult_b_q   <= 32'b0;
         unsigned_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            mult_a_q   <= a;
            mult_b_q   <= b;
            unsigned_q <= is_unsigned;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= 32'b0;
         lo_q <= 32'b0;
      end else if (capture) begin
         {hi_q, lo_q} <= product;
      end else begin
         if (mthi) hi_q <= wdata;
         if (mtlo) lo_q <= wdata;
      end
   end

endmodule

// File: doc/hilo_mult_ctrl.md
# hilo_mult_ctrl

Sequencer between the CPU control unit and the shared combinational 64-bit signed multiplier. It latches operands, holds multiplier enable for a fixed settle window, and corrects the signed product for MULTU. It captures the result into the architectural HI/LO registers and serves MTHI/MTLO writes. The CPU stalls on `busy` and resumes on `done`.

## Interface
- `MULT_CYCLES`, default 4: clock cycles the multiplier output needs to settle after operands and enable are stable; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to multiply `a` × `b`.
- `is_unsigned`  in  1  sampled with `start`: 1 = MULTU, 0 = MULT.
- `a`, `b`  in  32 each  operands, sampled with `start`.
- `mthi`, `mtlo`  in  1 each  write `wdata` into HI / LO.
- `wdata`  in  32  data for MTHI/MTLO.
- `mult_ena`  out  1  enable to multiplier.
- `mult_reset`  out  1  active-high reset to multiplier; equals `~reset` (combinational).
- `mult_a`, `mult_b`  out  32 each  registered operands to multiplier.
- `mult_z`  in  64  multiplier signed product.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.
- `busy`  out  1  multiply in progress; CPU must hold the instruction.
- `done`  out  1  one-cycle pulse; `hi`/`lo` already hold the new product.

## Operation
- FSM states: IDLE, RUN, DONE. Counter `cnt` is 4 bits.
- IDLE: on `start`, latch `a`→`mult_a`, `b`→`mult_b`, and `is_unsigned`. Load `cnt` = `MULT_CYCLES`. Go to RUN.
- RUN: `mult_ena`=1 and `busy`=1. Decrement `cnt` each cycle.
  - When `cnt`==0, capture the corrected product into {`hi`,`lo`} on that edge and go to DONE.
- DONE: `done`=1, `busy`=0, `mult_ena`=0. Next state is IDLE.
  - A `start` in DONE is accepted exactly as in IDLE, so back-to-back multiplies are allowed.
- Unsigned correction, mod 2^64: P = `mult_z` + (`mult_a`[31] ? {`mult_b`,32'b0} : 0) + (`mult_b`[31] ? {`mult_a`,32'b0} : 0).
- Signed multiply: P = `mult_z` unchanged.
- `start` while `busy`=1 is ignored; no queueing.
- MTHI/MTLO write on the edge they are sampled, in any state.
  - If a capture edge coincides with `mthi`/`mtlo`, the product wins and the MT write is dropped.
  - If `start` and `mthi`/`mtlo` occur in the same cycle, both take effect; the later product overwrites HI/LO.
- `mult_a`, `mult_b` and the unsigned flag hold their values outside RUN; they change only on an accepted `start`.

## Timing
- Reset asserted (async): state=IDLE, `cnt`=0, `mult_a`=`mult_b`=0, `hi`=`lo`=0, `busy`=0, `done`=0, `mult_ena`=0, `mult_reset`=1.
- Reset mid-RUN: all state clears immediately, no capture, no `done`.
- Reset deassertion is synchronous to `clk` at the system level; the first `start` may be sampled on the first rising edge after deassertion.
- `start` sampled at edge E0. `busy`=1 for cycles E0..E0+`MULT_CYCLES`, which is `MULT_CYCLES`+1 cycles.
- HI/LO update at edge E0+`MULT_CYCLES`+1.
- `done`=1 for the single following cycle.
- Start-to-done latency is `MULT_CYCLES`+1 cycles; throughput is one multiply per `MULT_CYCLES`+2 cycles.
- `mult_ena` is high throughout RUN. The multiplier output is treated as a `MULT_CYCLES`-cycle multicycle path from `mult_a`/`mult_b`.

## Test plan
- Reset: drive `reset`=0 mid-RUN with `MULT_CYCLES`=4 → `busy`, `done`, `mult_ena`, `hi`, `lo` = 0 immediately; `mult_reset`=1; no `done` after release.
- MULT -3 × 5 (0xFFFFFFFD, 0x00000005) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `done` exactly 5 cycles after the `start` edge; `busy` high 5 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - MULTU 0x80000000 × 2 → `hi`=0x00000001, `lo`=0x00000000.
  - MULT 0x80000000 × 2 → `hi`=0xFFFFFFFF, `lo`=0.
- Ignore while busy: second `start` (7 × 7) two cycles into RUN of 6 × 6 → only `hi`=0, `lo`=36; a single `done`.
  - A `start` (2 × 3) during the DONE cycle → accepted; `lo`=6 after 5 more cycles.
- MT collisions: `mthi` 0xAAAA5555 in IDLE → `hi`=0xAAAA5555, `lo` unchanged.
  - `mtlo` 0x1234 on the capture edge of 4 × 4 → `lo`=16.
  - `mtlo` together with `start` → `lo`=wdata, then the product.
